// File: rtl/accel_init.sv
// accel_init: power-up configuration sequencer for the ADXL362.
// After reset it waits for the device to power up, then sends three fixed
// write-register frames over SPI mode 0: soft reset, filter setup and
// measurement mode. It then raises init_done so the periodic reader can
// take over the shared SPI pins.
module accel_init #(
    parameter int HALF_CK = 4,
    parameter int WAIT_CK = 100_000
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       reinit,
    output logic       nCS,
    output logic       sclk,
    output logic       mosi,
    output logic       init_done,
    output logic [1:0] step
);

    localparam int CW = $clog2(WAIT_CK) + 1;

    typedef enum logic [3:0] {
        ST_PWR_WAIT  = 4'd0,
        ST_LOAD      = 4'd1,
        ST_CS_SETUP  = 4'd2,
        ST_SCLK_LO   = 4'd3,
        ST_SCLK_HI   = 4'd4,
        ST_CS_HOLD   = 4'd5,
        ST_GAP       = 4'd6,
        ST_POST_WAIT = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      bit_q, bit_d;
    logic [23:0]     sh_q, sh_d;
    logic [1:0]      step_q, step_d;
    logic            ncs_q, ncs_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            done_q, done_d;

    logic [CW-1:0]   len_s;
    logic            last_s;
    logic [23:0]     frame_s;

    // Frame table: command 0x0A, register address, register data.
    always_comb begin
        frame_s = 24'h0A2D02;
        case (step_q)
            2'd0:    frame_s = 24'h0A1F52;
            2'd1:    frame_s = 24'h0A2C13;
            2'd2:    frame_s = 24'h0A2D02;
            default: frame_s = 24'h0A2D02;
        endcase
    end

    // Length of the current state in ck cycles; last_s flags its final cycle.
    always_comb begin
        len_s = CW'(1);
        case (state_q)
            ST_PWR_WAIT,
            ST_POST_WAIT: len_s = CW'(WAIT_CK);
            ST_CS_SETUP,
            ST_SCLK_LO,
            ST_SCLK_HI,
            ST_CS_HOLD:   len_s = CW'(HALF_CK);
            ST_GAP:       len_s = CW'(2 * HALF_CK);
            default:      len_s = CW'(1);
        endcase
        last_s = (cnt_q == (len_s - CW'(1)));
    end

    // Next-state logic; outputs are derived from the next state so the pins
    // come straight from flops and change on the edge that enters a state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        step_d  = step_q;
        mosi_d  = mosi_q;

        case (state_q)
            ST_PWR_WAIT: begin
                if (last_s) state_d = ST_LOAD;
                else        state_d = ST_PWR_WAIT;
            end
            ST_LOAD: begin
                sh_d    = frame_s;
                bit_d   = 5'd0;
                mosi_d  = frame_s[23];
                state_d = ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                if (last_s) state_d = ST_SCLK_LO;
                else        state_d = ST_CS_SETUP;
            end
            ST_SCLK_LO: begin
                if (last_s) state_d = ST_SCLK_HI;
                else        state_d = ST_SCLK_LO;
            end
            ST_SCLK_HI: begin
                if (last_s) begin
                    if (bit_q == 5'd23) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        // Rotate rather than shift so every bit of the
                        // register stays live; only bit 23 is ever presented.
                        bit_d   = bit_q + 5'd1;
                        sh_d    = {sh_q[22:0], sh_q[23]};
                        mosi_d  = sh_q[22];
                        state_d = ST_SCLK_LO;
                    end
                end else begin
                    state_d = ST_SCLK_HI;
                end
            end
            ST_CS_HOLD: begin
                if (last_s) state_d = ST_GAP;
                else        state_d = ST_CS_HOLD;
            end
            ST_GAP: begin
                if (last_s) begin
                    case (step_q)
                        2'd0: state_d = ST_POST_WAIT;
                        2'd1: begin
                            step_d  = 2'd2;
                            state_d = ST_LOAD;
                        end
                        default: begin
                            mosi_d  = 1'b0;
                            state_d = ST_DONE;
                        end
                    endcase
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_POST_WAIT: begin
                if (last_s) begin
                    step_d  = 2'd1;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_POST_WAIT;
                end
            end
            ST_DONE: begin
                cnt_d  = cnt_q;
                mosi_d = 1'b0;
                if (reinit) begin
                    step_d  = 2'd0;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
            end
        endcase

        // The phase counter restarts on every state entry.
        if (state_d != state_q) cnt_d = CW'(0);
        else                    cnt_d = cnt_d;

        ncs_d  = !(state_d inside {ST_CS_SETUP, ST_SCLK_LO, ST_SCLK_HI, ST_CS_HOLD});
        sclk_d = (state_d == ST_SCLK_HI);
        done_d = (state_d == ST_DONE);
    end

    // State, counters and registered SPI pins; reset aborts any frame.
    always_ff @(posedge ck) begin
        if (reset) begin
            state_q <= ST_PWR_WAIT;
            cnt_q   <= CW'(0);
            bit_q   <= 5'd0;
            sh_q    <= 24'h000000;
            step_q  <= 2'd0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            step_q  <= step_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign nCS       = ncs_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign init_done = done_q;
    assign step      = step_q;

endmodule

// File: tb/tb_accel_init.sv
// Directed bench for accel_init with HALF_CK=2, WAIT_CK=20. A monitor
// captures each SPI frame on sclk rising edges along with its nCS fall/rise
// cycle indices; the main sequence compares them with hand-computed values.
module tb_accel_init;

    localparam int HALF_CK = 2;
    localparam int WAIT_CK = 20;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       reinit = 1'b0;
    logic       nCS, sclk, mosi, init_done;
    logic [1:0] step;

    accel_init #(.HALF_CK(HALF_CK), .WAIT_CK(WAIT_CK)) dut (
        .ck(ck), .reset(reset), .reinit(reinit),
        .nCS(nCS), .sclk(sclk), .mosi(mosi),
        .init_done(init_done), .step(step)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [23:0] data;
        int          bits;
        int          fall;
        int          rise;
        logic [1:0]  stp;
    } frame_t;

    frame_t      frames[$];
    int          cyc = 0;
    int          cur_bits = 0;
    logic [23:0] cur_data = 24'h0;
    int          cur_fall = 0;
    logic [1:0]  cur_step = 2'd0;
    int          done_rise = -1;
    int          mosi_viol = 0;
    int          sclk_viol = 0;
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_done = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Monitor: sample just after each clock edge, cyc = index of that edge.
    always @(posedge ck) begin
        #1;
        cyc = cyc + 1;
        if (prev_ncs === 1'b1 && nCS === 1'b0) begin
            cur_data = 24'h0;
            cur_bits = 0;
            cur_fall = cyc;
            cur_step = step;
        end
        if (nCS === 1'b0 && sclk === 1'b1 && prev_sclk === 1'b0) begin
            cur_data = {cur_data[22:0], mosi};
            cur_bits = cur_bits + 1;
        end
        if (nCS === 1'b0 && sclk === 1'b1 && prev_sclk === 1'b1 && mosi !== prev_mosi)
            mosi_viol = mosi_viol + 1;
        if (nCS === 1'b1 && sclk === 1'b1)
            sclk_viol = sclk_viol + 1;
        if (prev_ncs === 1'b0 && nCS === 1'b1)
            frames.push_back('{cur_data, cur_bits, cur_fall, cyc, cur_step});
        if (prev_done === 1'b0 && init_done === 1'b1)
            done_rise = cyc;
        prev_ncs  = nCS;
        prev_sclk = sclk;
        prev_mosi = mosi;
        prev_done = init_done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (got !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_frames(input int n, input string tag);
        int t = 0;
        while (frames.size() < n && t < 3000) begin
            @(negedge ck);
            t++;
        end
        chk(tag, 32'(frames.size()), 32'(n));
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (init_done !== 1'b1 && t < 3000) begin
            @(negedge ck);
            t++;
        end
        chk(tag, {31'd0, init_done}, 32'd1);
    endtask

    // Check the three frames of a full sequence held in frames[0..2].
    task automatic check_seq(input string tag);
        chk({tag, "_f0"}, {8'd0, frames[0].data}, 32'h000A1F52);
        chk({tag, "_f1"}, {8'd0, frames[1].data}, 32'h000A2C13);
        chk({tag, "_f2"}, {8'd0, frames[2].data}, 32'h000A2D02);
        chk({tag, "_s0"}, {30'd0, frames[0].stp}, 32'd0);
        chk({tag, "_s1"}, {30'd0, frames[1].stp}, 32'd1);
        chk({tag, "_s2"}, {30'd0, frames[2].stp}, 32'd2);
        chk({tag, "_gap01"}, 32'(frames[1].fall - frames[0].rise), 32'd25);
        chk({tag, "_gap12"}, 32'(frames[2].fall - frames[1].rise), 32'd5);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_bits"}, 32'(frames[i].bits), 32'd24);
            chk({tag, "_low"}, 32'(frames[i].rise - frames[i].fall), 32'd100);
        end
    endtask

    initial begin
        int c0;
        int t;
        int lows;

        // Reset state while reset is held.
        repeat (3) @(posedge ck);
        #1;
        chk("rst_ncs",  {31'd0, nCS}, 32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_done", {31'd0, init_done}, 32'd0);
        chk("rst_step", {30'd0, step}, 32'd0);

        // Release reset; c0 is the edge index before the last edge seeing reset=1.
        @(negedge ck);
        c0 = cyc;
        @(negedge ck);
        reset = 1'b0;
        frames.delete();

        // Pulse reinit during frame 2: must be ignored.
        wait_frames(2, "seq1_two");
        t = 0;
        while (nCS !== 1'b0 && t < 100) begin
            @(negedge ck);
            t++;
        end
        chk("f2_started", {31'd0, nCS}, 32'd0);
        repeat (10) @(negedge ck);
        reinit = 1'b1;
        @(negedge ck);
        reinit = 1'b0;

        wait_frames(3, "seq1_three");
        chk("first_fall", 32'(frames[0].fall - c0), 32'd22);
        check_seq("seq1");
        wait_done("seq1_done");
        chk("done_delay", 32'(done_rise - frames[2].rise), 32'd4);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ck);
            if (init_done !== 1'b1) lows++;
        end
        chk("done_stays", 32'(lows), 32'd0);
        chk("done_step", {30'd0, step}, 32'd2);
        chk("done_ncs", {31'd0, nCS}, 32'd1);

        // reinit in DONE.
        frames.delete();
        c0 = cyc;
        reinit = 1'b1;
        @(posedge ck);
        #1;
        chk("reinit_done_low", {31'd0, init_done}, 32'd0);
        @(negedge ck);
        reinit = 1'b0;
        wait_frames(3, "seq2_three");
        chk("reinit_fall", 32'(frames[0].fall - c0), 32'd2);
        check_seq("seq2");
        wait_done("seq2_done");

        // Reset 10 sclk edges into frame 1.
        frames.delete();
        reinit = 1'b1;
        @(negedge ck);
        reinit = 1'b0;
        t = 0;
        while (!(frames.size() == 1 && nCS === 1'b0 && cur_bits == 10) && t < 3000) begin
            @(negedge ck);
            t++;
        end
        chk("mid_f1_reached", 32'(cur_bits), 32'd10);
        c0 = cyc;
        reset = 1'b1;
        @(posedge ck);
        #1;
        chk("abort_ncs",  {31'd0, nCS}, 32'd1);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        chk("abort_step", {30'd0, step}, 32'd0);
        @(negedge ck);
        reset = 1'b0;
        frames.delete();
        wait_frames(1, "abort_one");
        chk("abort_fall", 32'(frames[0].fall - c0), 32'd22);
        chk("abort_f0", {8'd0, frames[0].data}, 32'h000A1F52);
        wait_frames(3, "abort_three");
        wait_done("abort_done");

        // Reset and reinit together in DONE: reset wins, power-up wait kept.
        frames.delete();
        c0 = cyc;
        reset  = 1'b1;
        reinit = 1'b1;
        @(posedge ck);
        #1;
        chk("both_done", {31'd0, init_done}, 32'd0);
        chk("both_ncs",  {31'd0, nCS}, 32'd1);
        chk("both_step", {30'd0, step}, 32'd0);
        @(negedge ck);
        reset  = 1'b0;
        reinit = 1'b0;
        wait_frames(1, "both_one");
        chk("both_fall", 32'(frames[0].fall - c0), 32'd22);
        chk("both_f0", {8'd0, frames[0].data}, 32'h000A1F52);

        chk("mosi_stable", 32'(mosi_viol), 32'd0);
        chk("sclk_idle",   32'(sclk_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/accel_init.md
# accel_init

Power-up configuration sequencer for the ADXL362 accelerometer. It sits upstream of the periodic register reader and drives the shared SPI pins (`nCS`, `sclk`, `mosi`) while configuration is in progress. After reset it issues a fixed series of SPI write-register frames: soft reset, filter setup, then measurement mode. It then raises `init_done`, which hands the SPI bus to the reader and enables the one-second read trigger.

## Interface
Parameters:
- `HALF_CK`, default 4: ck cycles per SCLK half-period; also the nCS setup, hold and gap unit. Minimum 2.
- `WAIT_CK`, default 100_000: ck cycles of the power-up wait and of the post-soft-reset wait (1 ms at 100 MHz).

Ports:
- `ck`  in  1  system clock, 100 MHz; the only clock.
- `reset`  in  1  synchronous, active-high. The top level feeds it the inverted board button.
- `reinit`  in  1  single-cycle request to rerun the sequence. Honoured only while `init_done`=1.
- `nCS`  out  1  SPI chip select, active low, registered.
- `sclk`  out  1  SPI clock, mode 0 (idles low), registered.
- `mosi`  out  1  SPI data out, registered.
- `init_done`  out  1  high when configuration is complete. While 0, the top level muxes this block's SPI pins onto the bus.
- `step`  out  2  index of the frame in progress (0..2); holds 2 after completion.

## Operation
- Frame format: 24 bits, sent MSB first: command 0x0A, then address, then data.
- Frame table, fixed:
  - step 0: 0x0A1F52 (SOFT_RESET ← 0x52)
  - step 1: 0x0A2C13 (FILTER_CTL ← 0x13)
  - step 2: 0x0A2D02 (POWER_CTL ← 0x02, measure mode)
- States and transitions:
  - PWR_WAIT: WAIT_CK cycles, then LOAD.
  - LOAD: 1 cycle. Loads the 24-bit shift register from the table entry for `step` and clears the bit counter. Then CS_SETUP.
  - CS_SETUP: nCS=0, sclk=0 for HALF_CK cycles. `mosi` presents bit 23 on entry.
  - SCLK_LO: HALF_CK cycles, sclk=0. Then SCLK_HI.
  - SCLK_HI: HALF_CK cycles, sclk=1; the device samples `mosi` on the rising edge.
    - If the bit counter is 23, go to CS_HOLD.
    - Otherwise increment the counter, shift left, present the next bit, and go to SCLK_LO.
  - CS_HOLD: HALF_CK cycles, sclk=0, nCS=0. Then GAP.
  - GAP: 2·HALF_CK cycles with nCS=1.
    - If step=0, go to POST_WAIT.
    - If step=1, increment step and go to LOAD.
    - If step=2, go to DONE.
  - POST_WAIT: WAIT_CK cycles. Then step←1 and go to LOAD.
  - DONE: init_done=1, nCS=1, sclk=0, mosi=0. A `reinit` pulse clears init_done, sets step←0 and goes to LOAD; the power-up wait is skipped.
- Counters:
  - Phase/wait counter: ⌈log2(WAIT_CK)⌉+1 bits, cleared on every state entry, terminal value = state length − 1.
  - Bit counter: 5 bits, range 0..23, never wraps.
- `mosi` changes only on the ck edge that starts SCLK_LO or CS_SETUP. It is stable for the whole SCLK_HI window.
- `reinit` while init_done=0 is ignored; it is not latched.
- Reset:
  - Outputs go to nCS=1, sclk=0, mosi=0, init_done=0, step=0.
  - State goes to PWR_WAIT on the next edge.
  - A frame in progress is aborted (nCS returns high on that edge), and the full sequence restarts, including the power-up wait.
- Reset and reinit asserted in the same cycle: reset wins.

## Timing
- nCS low per frame: HALF_CK + 48·HALF_CK + HALF_CK = 50·HALF_CK cycles (200 at default).
- First nCS fall: 1 + WAIT_CK + 1 cycles after reset deasserts (PWR_WAIT, then LOAD).
- Frame 0 nCS rise to frame 1 nCS fall: 2·HALF_CK + WAIT_CK + 1 cycles.
- Frame 1 nCS rise to frame 2 nCS fall: 2·HALF_CK + 1 cycles.
- Frame 2 nCS rise to init_done rise: 2·HALF_CK cycles.
- reinit in DONE to init_done low: 1 cycle. reinit to nCS fall: 2 cycles.
- Each SCLK period is 2·HALF_CK cycles, 50% duty (12.5 MHz at default).
- No combinational path from inputs to outputs.

## Test plan
All scenarios use HALF_CK=2, WAIT_CK=20, with the bench sampling mosi on every sclk rising edge.
- Release reset and hold it low. Required: nCS falls 22 cycles after release; frame 0 captures 0x0A1F52 in 24 rising edges; nCS is low for exactly 100 cycles; sclk is 0 whenever nCS=1.
- Full sequence. Required: frames 0x0A1F52, 0x0A2C13, 0x0A2D02 in that order; the gap between frame 0 and frame 1 is 25 cycles; step reads 0, 1, 2; init_done rises 4 cycles after the last nCS rise and stays 1.
- Assert reset for 1 cycle, 10 sclk edges into frame 1. Required: nCS=1 and sclk=0 on the next edge; step=0; the sequence restarts with the 20-cycle wait, then 0x0A1F52.
- Pulse reinit during frame 2. Required: no effect, and init_done rises on schedule. Then pulse reinit in DONE. Required: init_done=0 next cycle, nCS low 2 cycles after the pulse, and frames 0x0A1F52, 0x0A2C13, 0x0A2D02 are sent again.
- Assert reset and reinit in the same cycle while in DONE. Required: reset behaviour only, including the power-up wait.
- Check mosi stability. Required: mosi never toggles while sclk=1 and nCS=0 in any frame.
